seq_sub_slice: RTL



---
 rtl/seq_sub_slice.sv | 103 ++++++++++
 1 files changed

// File: rtl/seq_sub_slice.sv
`default_nettype none
// ============================================================================
// Module   : seq_sub_slice
// Purpose  : Multi-cycle a - b - bin, one 8-bit slice per clock, LSB first.
// Revision : 1.0  initial release
// ============================================================================
module seq_sub_slice #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int N  = WIDTH / 8;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [KW-1:0]    k;
  logic             c;
  logic [7:0]       a_sl;
  logic [7:0]       b_sl;
  logic [8:0]       slice_sum;
  logic             last_slice;
  logic             accept;

  // Subtraction as a + ~b + c, where c holds the inverted borrow.
  always_comb begin
    a_sl       = a_q[{k, 3'b000} +: 8];
    b_sl       = b_q[{k, 3'b000} +: 8];
    slice_sum  = {1'b0, a_sl} + {1'b0, ~b_sl} + {8'd0, c};
    last_slice = (k == K_LAST);
  end

  assign in_ready  = (state == IDLE) & ~rst;
  assign out_valid = (state == DONE) & ~rst;
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_slice) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      k    <= '0;
      c    <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
    end else if (accept) begin
      a_q <= a;
      b_q <= b;
      c   <= ~bin;
      k   <= '0;
    end else if (state == RUN) begin
      diff[{k, 3'b000} +: 8] <= slice_sum[7:0];
      c                      <= slice_sum[8];
      if (last_slice) begin
        bout <= ~slice_sum[8];
        ovf  <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (slice_sum[7] ^ a_q[WIDTH-1]);
      end else begin
        k <= k + KW'(1);
      end
    end
  end

endmodule
`default_nettype wire
